// File: rtl/pipe_wb_multi.sv
`default_nettype none
// ============================================================================
// Module   : pipe_wb_multi
// Brief    : Multi-lane, multi-stage write-back pipeline register with stall,
//            flush and a combinational forwarding lookup over in-flight writes.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_wb_multi #(
   parameter int DATA_WIDTH       = 32,
   parameter int REG_ADDR_WIDTH   = 5,
   parameter int LANES            = 2,
   parameter int DEPTH            = 1,
   parameter int READ_PORTS       = 2,
   parameter int ZERO_REG_DISCARD = 1
) (
   input  logic                                   i_Clk,
   input  logic                                   i_Reset,
   input  logic                                   i_Flush,
   input  logic                                   i_Stall,
   input  logic [LANES*DATA_WIDTH-1:0]            i_WriteBack_Data,
   input  logic [LANES-1:0]                       i_Writes_Back,
   input  logic [LANES*REG_ADDR_WIDTH-1:0]        i_Write_Addr,
   output logic [LANES*DATA_WIDTH-1:0]            o_WriteBack_Data,
   output logic [LANES-1:0]                       o_Writes_Back,
   output logic [LANES*REG_ADDR_WIDTH-1:0]        o_Write_Addr,
   input  logic [READ_PORTS*REG_ADDR_WIDTH-1:0]   i_Read_Addr,
   output logic [READ_PORTS-1:0]                  o_Fwd_Hit,
   output logic [READ_PORTS*DATA_WIDTH-1:0]       o_Fwd_Data,
   output logic [$clog2(LANES*DEPTH+1)-1:0]       o_Inflight
);
   localparam int CNT_W = $clog2(LANES*DEPTH+1);
   localparam int DW    = DATA_WIDTH;
   localparam int AW    = REG_ADDR_WIDTH;

   logic [DEPTH-1:0][LANES-1:0]    r_valid;
   logic [DEPTH-1:0][LANES*AW-1:0] r_addr;
   logic [DEPTH-1:0][LANES*DW-1:0] r_data;

   logic [LANES-1:0]    w_valid_in;
   logic [LANES*AW-1:0] w_addr_in;
   logic [LANES*DW-1:0] w_data_in;
   logic [CNT_W-1:0]    w_count;

   // Invalid lanes are zeroed on entry so every bubble is all-zero.
   generate
      for (genvar k = 0; k < LANES; k++) begin : g_lane_in
         assign w_valid_in[k] = i_Writes_Back[k] &&
                                !((ZERO_REG_DISCARD != 0) && (i_Write_Addr[k*AW +: AW] == '0));
         assign w_addr_in[k*AW +: AW] = w_valid_in[k] ? i_Write_Addr[k*AW +: AW] : '0;
         assign w_data_in[k*DW +: DW] = w_valid_in[k] ? i_WriteBack_Data[k*DW +: DW] : '0;
      end
   endgenerate

   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         r_valid <= '0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (i_Flush || !i_Stall) begin
         if (i_Flush) begin
            r_valid[0] <= '0;
            r_addr[0]  <= '0;
            r_data[0]  <= '0;
         end else begin
            r_valid[0] <= w_valid_in;
            r_addr[0]  <= w_addr_in;
            r_data[0]  <= w_data_in;
         end
         for (int s = 1; s < DEPTH; s++) begin
            r_valid[s] <= r_valid[s-1];
            r_addr[s]  <= r_addr[s-1];
            r_data[s]  <= r_data[s-1];
         end
      end
   end

   assign o_Writes_Back    = r_valid[DEPTH-1];
   assign o_Write_Addr     = r_addr[DEPTH-1];
   assign o_WriteBack_Data = r_data[DEPTH-1];

   // Scan oldest to youngest so the last match written is the youngest write.
   always_comb begin
      o_Fwd_Hit  = '0;
      o_Fwd_Data = '0;
      for (int r = 0; r < READ_PORTS; r++) begin
         for (int s = DEPTH-1; s >= 0; s--) begin
            for (int k = 0; k < LANES; k++) begin
               if (r_valid[s][k] &&
                   (r_addr[s][k*AW +: AW] == i_Read_Addr[r*AW +: AW]) &&
                   (i_Read_Addr[r*AW +: AW] != '0)) begin
                  o_Fwd_Hit[r]            = 1'b1;
                  o_Fwd_Data[r*DW +: DW]  = r_data[s][k*DW +: DW];
               end
            end
         end
      end
   end

   always_comb begin
      w_count = '0;
      for (int s = 0; s < DEPTH; s++) begin
         for (int k = 0; k < LANES; k++) begin
            w_count = w_count + CNT_W'(r_valid[s][k]);
         end
      end
   end

   assign o_Inflight = w_count;

endmodule
`default_nettype wire
